// File: rtl/operand_entry_pkg.sv
// Shared types and constants for the operand-entry stage feeding the 4-bit adder.
package operand_entry_pkg;

  localparam int NUM_KEYS = 16;  // hex digit pads
  localparam int DIGIT_W  = 4;   // bits per hex digit

  // Current entry field; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    ENTER_C = 2'd2,
    PRESENT = 2'd3
  } state_t;

endpackage

// File: rtl/key_edge.sv
// Press detector for the 16 hex pads plus enter and clear.
// Optional 2-flop input synchronizer when OPERAND_ENTRY_SYNC_EN is defined.
// Every flop resets to 1 so a key held through reset never reads as a press.
module key_edge
  import operand_entry_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_KEYS-1:0] i_keys,
  input  logic                i_enter,
  input  logic                i_clear,
  output logic                o_digit_hit,
  output logic [DIGIT_W-1:0]  o_digit,
  output logic                o_enter_hit,
  output logic                o_clear_hit
);

  localparam int NUM_IN = NUM_KEYS + 2;

  logic [NUM_IN-1:0] w_raw;
  logic [NUM_IN-1:0] w_in;
  logic [NUM_IN-1:0] r_sample;
  logic [NUM_IN-1:0] r_prev;
  logic [NUM_IN-1:0] w_rise;

  assign w_raw = {i_clear, i_enter, i_keys};

`ifdef OPERAND_ENTRY_SYNC_EN
  logic [NUM_IN-1:0] r_sync1;
  logic [NUM_IN-1:0] r_sync2;

  // Two-stage synchronizer for the asynchronous pushbutton inputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_in = r_sync2;
`else
  assign w_in = w_raw;
`endif

  // Sample register and its one-cycle-old copy for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sample <= '1;
      r_prev   <= '1;
    end else begin
      // NOTE: non-blocking so r_prev captures the old r_sample, not the new one.
      r_sample <= w_in;
      r_prev   <= r_sample;
    end
  end

  assign w_rise = r_sample & ~r_prev;

  // Lowest-index digit wins when several pads rise together.
  always_comb begin
    // NOTE: default first so every path assigns o_digit and no latch is inferred.
    o_digit = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (w_rise[i]) o_digit = DIGIT_W'(i);
    end
  end

  assign o_digit_hit = |w_rise[NUM_KEYS-1:0];
  assign o_enter_hit = w_rise[NUM_KEYS];
  assign o_clear_hit = w_rise[NUM_KEYS+1];

endmodule

// File: rtl/operand_entry.sv
// Operand-entry stage: collects A, B and carry-in from front-panel keys and
// hands them to the adder with a valid/ready handshake.
// Build option OPERAND_ENTRY_SYNC_EN adds a 2-flop key synchronizer (in key_edge).
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int WIDTH = 4  // multiple of 4, one hex digit per nibble
) (
  input  logic                hz100,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                enter,
  input  logic                clear,
  input  logic                op_ready,
  output logic [WIDTH-1:0]    opa,
  output logic [WIDTH-1:0]    opb,
  output logic                cin,
  output logic                op_valid,
  output logic [1:0]          state
);

  logic               w_digit_hit;
  logic [DIGIT_W-1:0] w_digit;
  logic               w_enter_hit;
  logic               w_clear_hit;
  logic               w_transfer;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   w_opa_next;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   w_opb_next;
  logic               r_cin;
  logic               w_cin_next;
  logic               r_op_valid;

  key_edge u_key_edge (
    .i_clk       (hz100),
    .i_rst_n     (reset_n),
    .i_keys      (keys),
    .i_enter     (enter),
    .i_clear     (clear),
    .o_digit_hit (w_digit_hit),
    .o_digit     (w_digit),
    .o_enter_hit (w_enter_hit),
    .o_clear_hit (w_clear_hit)
  );

  assign w_transfer = r_op_valid & op_ready;

  // State and field registers; op_valid is registered alongside PRESENT.
  always_ff @(posedge hz100) begin
    if (!reset_n) begin
      r_state    <= ENTER_A;
      r_opa      <= '0;
      r_opb      <= '0;
      r_cin      <= 1'b0;
      r_op_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_opa      <= w_opa_next;
      r_opb      <= w_opb_next;
      r_cin      <= w_cin_next;
      r_op_valid <= (w_state_next == PRESENT);
    end
  end

  // Field sequencing: clear beats everything, enter advances, transfer restarts.
  always_comb begin
    w_state_next = r_state;
    if (w_clear_hit) begin
      w_state_next = ENTER_A;
    end else begin
      case (r_state)
        ENTER_A: if (w_enter_hit) w_state_next = ENTER_B;
        ENTER_B: if (w_enter_hit) w_state_next = ENTER_C;
        ENTER_C: if (w_enter_hit) w_state_next = PRESENT;
        PRESENT: if (w_transfer)  w_state_next = ENTER_A;
        default: w_state_next = ENTER_A;
      endcase
    end
  end

  // Field updates: digits shift into A/B, 0/1 set carry-in, fields freeze in PRESENT.
  always_comb begin
    w_opa_next = r_opa;
    w_opb_next = r_opb;
    w_cin_next = r_cin;
    if (w_clear_hit) begin
      w_opa_next = '0;
      w_opb_next = '0;
      w_cin_next = 1'b0;
    end else begin
      case (r_state)
        ENTER_A: if (w_digit_hit) w_opa_next = WIDTH'({r_opa, w_digit});
        ENTER_B: if (w_digit_hit) w_opb_next = WIDTH'({r_opb, w_digit});
        ENTER_C: begin
          if (w_digit_hit && w_digit == 4'd0) w_cin_next = 1'b0;
          if (w_digit_hit && w_digit == 4'd1) w_cin_next = 1'b1;
        end
        PRESENT: begin
          if (w_transfer) begin
            w_opa_next = '0;
            w_opb_next = '0;
            w_cin_next = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign opa      = r_opa;
  assign opb      = r_opb;
  assign cin      = r_cin;
  assign op_valid = r_op_valid;
  assign state    = r_state;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry. A WIDTH=4 and a WIDTH=8 instance share the
// same stimulus; the 8-bit one exposes the digit shift/wrap behaviour.
`timescale 1ns/1ps
module tb_operand_entry;

`ifdef OPERAND_ENTRY_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        hz100    = 1'b0;
  logic        reset_n  = 1'b0;
  logic [15:0] keys     = '0;
  logic        enter    = 1'b0;
  logic        clear    = 1'b0;
  logic        op_ready = 1'b0;

  logic [3:0]  opa4, opb4;
  logic        cin4, valid4;
  logic [1:0]  state4;
  logic [7:0]  opa8, opb8;
  logic        cin8, valid8;
  logic [1:0]  state8;

  int n_checks = 0;
  int n_errors = 0;

  operand_entry #(.WIDTH(4)) dut4 (
    .hz100(hz100), .reset_n(reset_n), .keys(keys), .enter(enter), .clear(clear),
    .op_ready(op_ready), .opa(opa4), .opb(opb4), .cin(cin4), .op_valid(valid4),
    .state(state4)
  );

  operand_entry #(.WIDTH(8)) dut8 (
    .hz100(hz100), .reset_n(reset_n), .keys(keys), .enter(enter), .clear(clear),
    .op_ready(op_ready), .opa(opa8), .opb(opb8), .cin(cin8), .op_valid(valid8),
    .state(state8)
  );

  always #5 hz100 = ~hz100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge hz100);
    #1;
  endtask

  // Press for one cycle, release, and wait until the effect is visible.
  task automatic press(input logic [15:0] k, input logic e, input logic c);
    keys  = k;
    enter = e;
    clear = c;
    tick();
    keys  = '0;
    enter = 1'b0;
    clear = 1'b0;
    repeat (LAT) tick();
  endtask

  initial begin
    // Reset with keys[5] held.
    reset_n = 1'b0;
    keys    = 16'h0020;
    repeat (3) tick();
    check("rst_state", state4, 0);
    check("rst_opa", opa4, 0);
    check("rst_opb", opb4, 0);
    check("rst_cin", cin4, 0);
    check("rst_valid", valid4, 0);
    reset_n = 1'b1;
    repeat (10) tick();
    check("held_key_ignored", opa4, 0);
    keys = '0;
    repeat (LAT + 1) tick();
    keys = 16'h0020;
    tick();
    check("press_not_early", opa4, 0);
    keys = '0;
    repeat (LAT) tick();
    check("press_latency_opa4", opa4, 4'h5);
    check("press_latency_opa8", opa8, 8'h05);

    // Full entry A=3, B=9, cin=1 with op_ready low.
    press(16'h0000, 1'b0, 1'b1);
    check("clr_opa", opa4, 0);
    press(16'h0008, 1'b0, 1'b0);
    check("a_digit", opa4, 4'h3);
    press(16'h0000, 1'b1, 1'b0);
    check("to_b", state4, 1);
    press(16'h0200, 1'b0, 1'b0);
    check("b_digit", opb4, 4'h9);
    press(16'h0000, 1'b1, 1'b0);
    check("to_c", state4, 2);
    check("c_not_valid", valid4, 0);
    press(16'h0002, 1'b0, 1'b0);
    check("c_one", cin4, 1);
    press(16'h0000, 1'b1, 1'b0);
    check("present_state", state4, 3);
    check("present_valid", valid4, 1);
    check("present_opa8", opa8, 8'h03);
    check("present_opb8", opb8, 8'h09);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_valid", valid4, 1);
      check("hold_opa", opa4, 4'h3);
      check("hold_opb", opb4, 4'h9);
      check("hold_cin", cin4, 1);
    end
    press(16'h0080, 1'b0, 1'b0);
    check("present_digit_ignored", opa4, 4'h3);
    press(16'h0000, 1'b1, 1'b0);
    check("present_enter_ignored", state4, 3);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("xfer_valid", valid4, 0);
    check("xfer_state", state4, 0);
    check("xfer_opa", opa4, 0);
    check("xfer_opb", opb4, 0);
    check("xfer_cin", cin4, 0);

    // Priority encode and digit+enter on one edge.
    press(16'h0084, 1'b0, 1'b0);
    check("prio_lowest", opa4, 4'h2);
    press(16'h4000, 1'b1, 1'b0);
    check("digit_enter_opa", opa4, 4'hE);
    check("digit_enter_state", state4, 1);
    check("shift_opa8", opa8, 8'h2E);
    press(16'h0000, 1'b1, 1'b1);
    check("clear_beats_enter", state4, 0);
    check("clear_opa", opa4, 0);

    // Carry-in field: only 0 and 1 matter.
    press(16'h0000, 1'b1, 1'b0);
    press(16'h0000, 1'b1, 1'b0);
    check("in_c", state4, 2);
    press(16'h0010, 1'b0, 1'b0);
    check("c_4_ignored_lo", cin4, 0);
    press(16'h0002, 1'b0, 1'b0);
    check("c_set", cin4, 1);
    press(16'h0010, 1'b0, 1'b0);
    check("c_4_ignored_hi", cin4, 1);
    press(16'h0001, 1'b0, 1'b0);
    check("c_zero", cin4, 0);
    press(16'h0000, 1'b0, 1'b1);

    // Multi-digit entry: A, B, C.
    press(16'h0400, 1'b0, 1'b0);
    press(16'h0800, 1'b0, 1'b0);
    press(16'h1000, 1'b0, 1'b0);
    check("wrap_opa8", opa8, 8'hBC);
    check("wrap_opa4", opa4, 4'hC);

    // Clear on the transfer cycle.
    press(16'h0000, 1'b1, 1'b0);
    press(16'h0000, 1'b1, 1'b0);
    press(16'h0000, 1'b1, 1'b0);
    check("pre_clr_valid", valid4, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (LAT - 1) tick();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("clr_xfer_state", state4, 0);
    check("clr_xfer_opa", opa4, 0);
    check("clr_xfer_valid", valid4, 0);

    // Reset mid-entry discards partial operand.
    press(16'h0080, 1'b0, 1'b0);
    check("mid_opa", opa4, 4'h7);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_opa", opa4, 0);
    check("mid_rst_state", state4, 0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
